// File: rtl/xmon_pkg.sv
// Shared types and helpers for the multi-channel XADC monitor.
package xmon_pkg;

  localparam int CODE_W     = 12;
  localparam int XADC_CH_W  = 5;
  localparam int DRP_ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    STORE
  } xmon_state_e;

  // XADC status/aux result registers sit at the DRP address equal to the channel number
  function automatic logic [DRP_ADDR_W-1:0] ch_to_daddr(input logic [XADC_CH_W-1:0] ch);
    return {2'b00, ch};
  endfunction

endpackage

// File: rtl/xmon_chan.sv
// Per-channel sample register, optional averaging and sticky OV/UV flags with hysteresis.
// Build option: define XMON_AVG_EN to average 2^AVG_LOG2 samples before publishing a code.
module xmon_chan
  import xmon_pkg::*;
#(
  parameter logic [CODE_W-1:0] HYST = 12'd16
`ifdef XMON_AVG_EN
  ,
  parameter int AVG_LOG2 = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store,
  input  logic [CODE_W-1:0] code_in,
  input  logic [CODE_W-1:0] ov_thresh,
  input  logic [CODE_W-1:0] uv_thresh,
  input  logic              fault_clr,
  output logic [CODE_W-1:0] sample_code,
  output logic              sample_valid,
  output logic              ov_flag,
  output logic              uv_flag
);

  logic              upd;
  logic [CODE_W-1:0] new_code;
  logic [CODE_W-1:0] eval_code;
  logic [CODE_W-1:0] ov_lim;
  logic [CODE_W:0]   uv_sum;
  logic [CODE_W-1:0] uv_lim;
  logic              ov_set;
  logic              uv_set;
  logic              ov_clr;
  logic              uv_clr;

`ifdef XMON_AVG_EN
  logic [CODE_W+AVG_LOG2-1:0] acc;
  logic [CODE_W+AVG_LOG2-1:0] acc_sum;
  logic [AVG_LOG2-1:0]        cnt;

  assign acc_sum  = acc + {{AVG_LOG2{1'b0}}, code_in};
  assign upd      = store && (cnt == {AVG_LOG2{1'b1}});
  assign new_code = acc_sum[CODE_W+AVG_LOG2-1:AVG_LOG2];

  // Accumulate one window of samples; restart once the window's last sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (store) begin
      if (upd) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign upd      = store;
  assign new_code = code_in;
`endif

  // Clear limits are pulled back inside the trip points by HYST and clamped to the code range
  assign ov_lim    = (ov_thresh < HYST) ? '0 : (ov_thresh - HYST);
  assign uv_sum    = {1'b0, uv_thresh} + {1'b0, HYST};
  assign uv_lim    = uv_sum[CODE_W] ? '1 : uv_sum[CODE_W-1:0];
  assign eval_code = upd ? new_code : sample_code;
  assign ov_set    = upd && (new_code > ov_thresh);
  assign uv_set    = upd && (new_code < uv_thresh);
  assign ov_clr    = fault_clr && (eval_code <= ov_lim);
  assign uv_clr    = fault_clr && (eval_code >= uv_lim);

  // Publish the code and update sticky flags; a set condition beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_code  <= '0;
      sample_valid <= 1'b0;
      ov_flag      <= 1'b0;
      uv_flag      <= 1'b0;
    end else begin
      sample_valid <= upd;
      if (upd) sample_code <= new_code;
      ov_flag <= ov_set | (ov_flag & ~ov_clr);
      uv_flag <= uv_set | (uv_flag & ~uv_clr);
    end
  end

endmodule

// File: rtl/xadc_multi_monitor.sv
// Multi-channel XADC supervisor: matches EOCs, runs DRP reads, tracks overruns and timeouts.
// Build option: define XMON_AVG_EN to enable per-channel averaging in xmon_chan.
module xadc_multi_monitor
  import xmon_pkg::*;
#(
  parameter int NUM_CH = 4,
  // index 0 = 0x1D, 1 = 0x1C, 2 = 0x1E, 3 = 0x1F
  parameter logic [NUM_CH*XADC_CH_W-1:0] CH_SEL = {5'h1F, 5'h1E, 5'h1C, 5'h1D},
  parameter int TIMEOUT_CYC = 64,
  parameter logic [CODE_W-1:0] HYST = 12'd16,
  parameter int AVG_LOG2 = 3
) (
  input  logic                     clk_ctrl,
  input  logic                     rst_ctrl,
  input  logic                     eoc_in,
  input  logic [XADC_CH_W-1:0]     channel_in,
  output logic                     drp_den,
  output logic [DRP_ADDR_W-1:0]    drp_daddr,
  input  logic                     drp_drdy,
  input  logic [15:0]              drp_do,
  input  logic [NUM_CH*CODE_W-1:0] ov_thresh,
  input  logic [NUM_CH*CODE_W-1:0] uv_thresh,
  input  logic                     fault_clr,
  output logic [NUM_CH*CODE_W-1:0] sample_code,
  output logic [NUM_CH-1:0]        sample_valid,
  output logic [NUM_CH-1:0]        ov_flag,
  output logic [NUM_CH-1:0]        uv_flag,
  output logic                     drp_timeout,
  output logic [7:0]               overrun_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  xmon_state_e       state;
  xmon_state_e       state_next;
  logic              match_hit;
  logic [IDX_W-1:0]  match_idx;
  logic [IDX_W-1:0]  cur_idx;
  logic              pend_full;
  logic [IDX_W-1:0]  pend_idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              eoc_hit;
  logic              take_pend;
  logic              take_eoc;
  logic              go_req;
  logic              to_pend;
  logic              drop;
  logic              tmo_hit;
  logic              tmo_evt;
  logic              store_hit;

  // Lowest index wins if a channel number appears twice in CH_SEL
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (channel_in == CH_SEL[i*XADC_CH_W +: XADC_CH_W]) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  assign eoc_hit   = eoc_in && match_hit;
  assign take_pend = (state == IDLE) && pend_full;
  assign take_eoc  = (state == IDLE) && !pend_full && eoc_hit;
  assign go_req    = take_pend || take_eoc;
  assign to_pend   = eoc_hit && !take_eoc;
  assign drop      = to_pend && pend_full && !take_pend;
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign tmo_evt   = (state == WAIT) && !drp_drdy && tmo_hit;
  assign store_hit = (state == WAIT) && drp_drdy;

  // State register
  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and the DRP enable strobe
  always_comb begin
    state_next = state;
    drp_den    = 1'b0;
    case (state)
      IDLE:  if (go_req) state_next = REQ;
      REQ: begin
        drp_den    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (drp_drdy)     state_next = STORE;
        else if (tmo_hit) state_next = IDLE;
      end
      STORE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read bookkeeping: active channel, DRP address, pending slot, timeout and overrun tracking
  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      cur_idx     <= '0;
      drp_daddr   <= '0;
      pend_full   <= 1'b0;
      pend_idx    <= '0;
      tmo_cnt     <= '0;
      drp_timeout <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (go_req) begin
        cur_idx   <= take_pend ? pend_idx : match_idx;
        drp_daddr <= ch_to_daddr(CH_SEL[(take_pend ? pend_idx : match_idx)*XADC_CH_W +: XADC_CH_W]);
      end
      if (to_pend && !drop) begin
        pend_full <= 1'b1;
        pend_idx  <= match_idx;
      end else if (take_pend) begin
        pend_full <= 1'b0;
      end
      if (state == REQ)       tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_evt)        drp_timeout <= 1'b1;
      else if (fault_clr) drp_timeout <= 1'b0;
      if (fault_clr)                 overrun_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    xmon_chan #(
      .HYST(HYST)
`ifdef XMON_AVG_EN
      ,
      .AVG_LOG2(AVG_LOG2)
`endif
    ) u_chan (
      .clk          (clk_ctrl),
      .rst          (rst_ctrl),
      .store        (store_hit && (cur_idx == IDX_W'(g))),
      .code_in      (drp_do[15:4]),
      .ov_thresh    (ov_thresh[g*CODE_W +: CODE_W]),
      .uv_thresh    (uv_thresh[g*CODE_W +: CODE_W]),
      .fault_clr    (fault_clr),
      .sample_code  (sample_code[g*CODE_W +: CODE_W]),
      .sample_valid (sample_valid[g]),
      .ov_flag      (ov_flag[g]),
      .uv_flag      (uv_flag[g])
    );
  end

endmodule
